// File: rtl/ycbcr_pkg.sv
// Shared lane map, pair-state encoding and word packing for the 4:4:4 -> 4:2:2 packer.
package ycbcr_pkg;

  localparam int PIX_W  = 24;
  localparam int PAIR_W = 32;

  localparam int unsigned LANE_Y  = 0;
  localparam int unsigned LANE_CB = 1;
  localparam int unsigned LANE_CR = 2;

  localparam int unsigned UYVY_CB = 0;
  localparam int unsigned UYVY_Y0 = 1;
  localparam int unsigned UYVY_CR = 2;
  localparam int unsigned UYVY_Y1 = 3;

  typedef enum logic {
    EMPTY,
    HAVE_ONE
  } pair_state_t;

  function automatic logic [7:0] lane(input logic [PIX_W-1:0] pix, input int unsigned idx);
    return pix[idx*8 +: 8];
  endfunction

  function automatic logic [PAIR_W-1:0] pack_uyvy(input logic [7:0] y0, input logic [7:0] cb,
                                                  input logic [7:0] y1, input logic [7:0] cr);
    logic [PAIR_W-1:0] word;
    word = '0;
    word[UYVY_CB*8 +: 8] = cb;
    word[UYVY_Y0*8 +: 8] = y0;
    word[UYVY_CR*8 +: 8] = cr;
    word[UYVY_Y1*8 +: 8] = y1;
    return word;
  endfunction

endpackage

// File: rtl/chroma_avg2.sv
// Rounded average of two 8-bit chroma samples; 9-bit sum so 0xFF+0xFF cannot wrap.
module chroma_avg2 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] avg
);

  assign avg = 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);

endmodule

// File: rtl/ycbcr422_packer.sv
// Pairs adjacent 4:4:4 pixels into UYVY 4:2:2 words with AXI4-Stream backpressure and framing.
module ycbcr422_packer
  import ycbcr_pkg::*;
#(
  parameter bit CHROMA_AVG = 1'b1,
  parameter bit PAD_ODD    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  output logic              s_axis_video_tready,
  input  logic              s_axis_video_tlast,
  input  logic              s_axis_video_tuser,
  output logic [PAIR_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  output logic              err_resync,
  output logic              err_odd
);

  pair_state_t state;
  logic [7:0]  held_y, held_cb, held_cr;
  logic        held_user;
  logic [7:0]  in_y, in_cb, in_cr;
  logic [7:0]  avg_cb, avg_cr, pair_cb, pair_cr;
  logic        accept, first;

  assign s_axis_video_tready = !m_axis_video_tvalid || m_axis_video_tready;
  assign accept = s_axis_video_tvalid && s_axis_video_tready;
  // A tuser beat always restarts pairing, even when a pixel is already held.
  assign first  = (state == EMPTY) || s_axis_video_tuser;

  assign in_y  = lane(s_axis_video_tdata, LANE_Y);
  assign in_cb = lane(s_axis_video_tdata, LANE_CB);
  assign in_cr = lane(s_axis_video_tdata, LANE_CR);

  chroma_avg2 u_avg_cb (.a(held_cb), .b(in_cb), .avg(avg_cb));
  chroma_avg2 u_avg_cr (.a(held_cr), .b(in_cr), .avg(avg_cr));

  assign pair_cb = CHROMA_AVG ? avg_cb : held_cb;
  assign pair_cr = CHROMA_AVG ? avg_cr : held_cr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= EMPTY;
      held_y              <= '0;
      held_cb             <= '0;
      held_cr             <= '0;
      held_user           <= 1'b0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      err_resync          <= 1'b0;
      err_odd             <= 1'b0;
    end else begin
      err_resync <= accept && (state == HAVE_ONE) && s_axis_video_tuser;
      err_odd    <= accept && first && s_axis_video_tlast;
      if (m_axis_video_tvalid && m_axis_video_tready)
        m_axis_video_tvalid <= 1'b0;
      if (accept) begin
        if (first) begin
          if (s_axis_video_tlast) begin
            state <= EMPTY;
            if (PAD_ODD) begin
              m_axis_video_tvalid <= 1'b1;
              m_axis_video_tdata  <= pack_uyvy(in_y, in_cb, in_y, in_cr);
              m_axis_video_tlast  <= 1'b1;
              m_axis_video_tuser  <= s_axis_video_tuser;
            end
          end else begin
            state     <= HAVE_ONE;
            held_y    <= in_y;
            held_cb   <= in_cb;
            held_cr   <= in_cr;
            held_user <= s_axis_video_tuser;
          end
        end else begin
          state               <= EMPTY;
          m_axis_video_tvalid <= 1'b1;
          m_axis_video_tdata  <= pack_uyvy(held_y, pair_cb, in_y, pair_cr);
          m_axis_video_tlast  <= s_axis_video_tlast;
          m_axis_video_tuser  <= held_user;
        end
      end
    end
  end

endmodule
